// File: rtl/scancode_matrix_mapper_pkg.sv
// Shared types, widths and helpers for the scancode-to-matrix mapper.
package scancode_matrix_mapper_pkg;

  localparam int unsigned DEF_ROWS          = 8;
  localparam int unsigned DEF_COLS          = 5;
  localparam int unsigned DEF_KEYS_PER_SCAN = 2;
  localparam int unsigned DEF_MOD_BITS      = 3;
  localparam int unsigned DEF_SLOTS         = 8;

  // Keymap entry {row, colmask} at the default geometry; colmask 0 is "no key".
  localparam int unsigned ENTRY_W = $clog2(DEF_ROWS) + DEF_COLS;
  localparam logic [ENTRY_W-1:0] NULL_ENTRY = '0;

  // Default modifier bit order in the keymap address.
  typedef struct packed {
    logic alt;
    logic ctrl;
    logic shift;
  } mods_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_LOOKUP,
    ST_CPUTIME,
    ST_CPUREAD,
    ST_CPUWRITE,
    ST_CPUINC
  } state_t;

  function automatic int unsigned entry_w(input int unsigned rows, input int unsigned cols);
    return $clog2(rows) + cols;
  endfunction

  // CPU pointer walks every plane of every keymap entry: {entry address, plane}.
  function automatic int unsigned cpu_addr_w(input int unsigned mod_bits, input int unsigned kps);
    return mod_bits + 8 + $clog2(kps);
  endfunction

endpackage

// File: rtl/scancode_matrix_mapper_if.sv
// Scancode event, matrix read and CPU keymap port bundle.
interface scancode_matrix_mapper_if #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 5,
  parameter int unsigned MOD_BITS = 3
);
  logic                scan_received;
  logic [6:0]          scan;
  logic                extended;
  logic                released;
  logic [MOD_BITS-1:0] modifiers;
  logic                kbclean;
  logic [ROWS-1:0]     sp_row;
  logic [COLS-1:0]     sp_col;
  logic [7:0]          din;
  logic [7:0]          dout;
  logic                cpuwrite;
  logic                cpuread;
  logic                rewind;
  logic                overflow;

  modport master (
    output scan_received, scan, extended, released, modifiers, kbclean,
    output sp_row, din, cpuwrite, cpuread, rewind,
    input  sp_col, dout, overflow
  );

  modport slave (
    input  scan_received, scan, extended, released, modifiers, kbclean,
    input  sp_row, din, cpuwrite, cpuread, rewind,
    output sp_col, dout, overflow
  );
endinterface

// File: rtl/scancode_matrix_mapper_ram.sv
// One keymap plane: single-port synchronous RAM, read-before-write.
module keymap_plane_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [1 << AW];

  // Contents are not reset; they survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/scancode_matrix_mapper.sv
// Maps PS/2 scancode events through keymap planes onto an active-low key
// matrix, tracking held keys so a release undoes exactly what its press set.
module scancode_matrix_mapper
  import scancode_matrix_mapper_pkg::*;
#(
  parameter int unsigned ROWS          = DEF_ROWS,
  parameter int unsigned COLS          = DEF_COLS,
  parameter int unsigned KEYS_PER_SCAN = DEF_KEYS_PER_SCAN,
  parameter int unsigned MOD_BITS      = DEF_MOD_BITS,
  parameter int unsigned SLOTS         = DEF_SLOTS
) (
  input logic clk,
  input logic rst_n,
  scancode_matrix_mapper_if.slave bus
);
  localparam int unsigned RB  = $clog2(ROWS);
  localparam int unsigned EW  = entry_w(ROWS, COLS);
  localparam int unsigned KPS = KEYS_PER_SCAN;
  localparam int unsigned PB  = $clog2(KPS);
  localparam int unsigned KAW = MOD_BITS + 8;
  localparam int unsigned CAW = cpu_addr_w(MOD_BITS, KPS);
  localparam int unsigned SW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  state_t              state;
  logic                pending;
  logic [MOD_BITS-1:0] pend_mod, cur_mod;
  logic                pend_ext, cur_ext;
  logic [6:0]          pend_scan, cur_scan;
  logic                pend_rel, cur_rel;
  logic [CAW-1:0]      cpuaddr;
  logic [7:0]          dout_q;
  logic                overflow_q;

  logic [SLOTS-1:0]    slot_valid;
  logic [7:0]          slot_key   [SLOTS];
  logic [EW-1:0]       slot_entry [SLOTS][KPS];

  logic [KAW-1:0]      ram_addr;
  logic [KPS-1:0]      ram_we;
  logic [KPS-1:0]      plane_hit;
  logic [EW-1:0]       ram_rdata [KPS];

  logic                hit, free;
  logic [SW-1:0]       hit_idx, free_idx;
  logic [COLS-1:0]     row_mask [ROWS];
  logic [COLS-1:0]     col_c;

  // SEARCH owns the RAM address for the lookup; otherwise the CPU pointer does.
  assign ram_addr = (state == ST_SEARCH) ? {cur_mod, cur_ext, cur_scan}
                                         : KAW'(cpuaddr >> PB);

  for (genvar p = 0; p < KPS; p++) begin : g_plane
    assign plane_hit[p] = (CAW'(p) == (cpuaddr & CAW'(KPS - 1)));
    assign ram_we[p]    = (state == ST_CPUWRITE) && plane_hit[p];

    keymap_plane_ram #(.AW(KAW), .DW(EW)) u_ram (
      .clk   (clk),
      .we    (ram_we[p]),
      .addr  (ram_addr),
      .wdata (bus.din[EW-1:0]),
      .rdata (ram_rdata[p])
    );
  end

  // Held-slot match for the current event and lowest free slot.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_valid[s] && slot_key[s] == {cur_ext, cur_scan}) begin
        hit     = 1'b1;
        hit_idx = SW'(s);
      end
    end
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (!slot_valid[s]) begin
        free     = 1'b1;
        free_idx = SW'(s);
      end
    end
  end

  // Per-row OR of held column masks, then AND across selected rows.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_mask[r] = '0;
      for (int s = 0; s < SLOTS; s++) begin
        for (int k = 0; k < KPS; k++) begin
          if (slot_valid[s] && slot_entry[s][k][EW-1 -: RB] == RB'(r))
            row_mask[r] = row_mask[r] | slot_entry[s][k][COLS-1:0];
        end
      end
    end
    col_c = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!bus.sp_row[r]) col_c = col_c & ~row_mask[r];
    end
  end

  assign bus.sp_col   = col_c;
  assign bus.dout     = dout_q;
  assign bus.overflow = overflow_q;

  // Control FSM, slot table, CPU pointer and event latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      pend_mod   <= '0;
      pend_ext   <= 1'b0;
      pend_scan  <= '0;
      pend_rel   <= 1'b0;
      cur_mod    <= '0;
      cur_ext    <= 1'b0;
      cur_scan   <= '0;
      cur_rel    <= 1'b0;
      cpuaddr    <= '0;
      dout_q     <= '0;
      overflow_q <= 1'b0;
      slot_valid <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        slot_key[s] <= '0;
        for (int k = 0; k < KPS; k++) slot_entry[s][k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) begin
            state    <= ST_SEARCH;
            pending  <= 1'b0;
            cur_mod  <= pend_mod;
            cur_ext  <= pend_ext;
            cur_scan <= pend_scan;
            cur_rel  <= pend_rel;
          end else if (bus.cpuread || bus.cpuwrite || bus.rewind) begin
            state <= ST_CPUTIME;
          end else if (bus.kbclean) begin
            // Nothing physically down: drop anything a lost break code left behind.
            slot_valid <= '0;
          end
        end
        ST_SEARCH: begin
          state <= ST_IDLE;
          if (cur_rel) begin
            if (hit) slot_valid[hit_idx] <= 1'b0;
          end else if (!hit) begin
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          state <= ST_IDLE;
          if (free) begin
            slot_valid[free_idx] <= 1'b1;
            slot_key[free_idx]   <= {cur_ext, cur_scan};
            for (int k = 0; k < KPS; k++) slot_entry[free_idx][k] <= ram_rdata[k];
          end else begin
            overflow_q <= 1'b1;
          end
        end
        ST_CPUTIME: begin
          if (bus.rewind) begin
            cpuaddr    <= '0;
            overflow_q <= 1'b0;
            state      <= ST_IDLE;
          end else if (bus.cpuread) begin
            state <= ST_CPUREAD;
          end else if (bus.cpuwrite) begin
            state <= ST_CPUWRITE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CPUREAD: begin
          for (int p = 0; p < KPS; p++) begin
            if (plane_hit[p]) dout_q <= 8'(ram_rdata[p]);
          end
          state <= ST_CPUINC;
        end
        ST_CPUWRITE: state <= ST_CPUINC;
        ST_CPUINC: begin
          if (!bus.cpuread && !bus.cpuwrite) begin
            cpuaddr <= cpuaddr + CAW'(1);
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Latest strobe wins and beats the pending clear on the same edge.
      if (bus.scan_received) begin
        pending   <= 1'b1;
        pend_mod  <= bus.modifiers;
        pend_ext  <= bus.extended;
        pend_scan <= bus.scan;
        pend_rel  <= bus.released;
      end
    end
  end

endmodule

// File: tb/tb_scancode_matrix_mapper.sv
// Randomized self-checking bench with a held-key set reference model.
module tb_scancode_matrix_mapper;
  import scancode_matrix_mapper_pkg::*;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 5;
  localparam int unsigned KPS   = 2;
  localparam int unsigned MODB  = 3;
  localparam int unsigned SLOTS = 8;
  localparam int unsigned NADDR = 512;  // keymap entries with alt=ctrl=0

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scancode_matrix_mapper_if #(.ROWS(ROWS), .COLS(COLS), .MOD_BITS(MODB)) bus ();

  scancode_matrix_mapper #(
    .ROWS(ROWS), .COLS(COLS), .KEYS_PER_SCAN(KPS), .MOD_BITS(MODB), .SLOTS(SLOTS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: keymap contents, set of held keys with press-time entries.
  typedef struct packed {
    logic [7:0]                    key;
    logic [KPS-1:0][ENTRY_W-1:0]   e;
  } held_t;

  logic [ENTRY_W-1:0] km [KPS][NADDR];
  held_t              held[$];
  logic               ovf_m = 1'b0;

  function automatic logic [COLS-1:0] exp_col(input logic [ROWS-1:0] rsel);
    logic [COLS-1:0] res;
    logic [COLS-1:0] m;
    res = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!rsel[r]) begin
        m = '0;
        foreach (held[i])
          for (int k = 0; k < KPS; k++)
            if (int'(held[i].e[k][7:5]) == r) m |= held[i].e[k][4:0];
        res &= ~m;
      end
    end
    return res;
  endfunction

  task automatic model_event(input logic [2:0] mod, input logic ext, input logic [6:0] sc,
                             input logic rel);
    logic [7:0] key;
    int idx;
    held_t h;
    key = {ext, sc};
    idx = -1;
    foreach (held[i]) if (held[i].key == key) idx = i;
    if (rel) begin
      if (idx >= 0) held.delete(idx);
    end else if (idx < 0) begin
      if (held.size() == SLOTS) ovf_m = 1'b1;
      else begin
        h.key = key;
        for (int k = 0; k < KPS; k++) h.e[k] = km[k][int'(mod) * 256 + int'(key)];
        held.push_back(h);
      end
    end
  endtask

  task automatic send(input logic [2:0] mod, input logic ext, input logic [6:0] sc,
                      input logic rel);
    @(negedge clk);
    bus.modifiers = mod; bus.extended = ext; bus.scan = sc; bus.released = rel;
    bus.scan_received = 1'b1;
    @(negedge clk);
    bus.scan_received = 1'b0;
    repeat (4) @(negedge clk);
    model_event(mod, ext, sc, rel);
  endtask

  task automatic kb_clean();
    @(negedge clk); bus.kbclean = 1'b1;
    @(negedge clk); bus.kbclean = 1'b0;
    @(negedge clk);
    held.delete();
  endtask

  task automatic cpu_rewind();
    @(negedge clk); bus.rewind = 1'b1;
    repeat (2) @(negedge clk);
    bus.rewind = 1'b0;
    @(negedge clk);
    ovf_m = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    @(negedge clk); bus.din = d; bus.cpuwrite = 1'b1;
    repeat (3) @(negedge clk);
    bus.cpuwrite = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_read(output logic [7:0] d);
    @(negedge clk); bus.cpuread = 1'b1;
    repeat (3) @(negedge clk);
    d = bus.dout;
    bus.cpuread = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_matrix(input string tag);
    logic [ROWS-1:0] rsel;
    for (int r = 0; r <= ROWS; r++) begin
      @(negedge clk);
      rsel = (r == ROWS) ? '0 : ~(ROWS'(1) << r);
      bus.sp_row = rsel;
      #1;
      check_eq({tag, "_col"}, 32'(bus.sp_col), 32'(exp_col(rsel)));
    end
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf_m));
  endtask

  initial begin
    logic [7:0] rd;
    logic [ROWS-1:0] rsel;
    mods_t ms;
    logic rel, ext;
    logic [6:0] sc;

    bus.scan_received = 1'b0; bus.scan = '0; bus.extended = 1'b0; bus.released = 1'b0;
    bus.modifiers = '0; bus.kbclean = 1'b0; bus.sp_row = '0; bus.din = '0;
    bus.cpuwrite = 1'b0; bus.cpuread = 1'b0; bus.rewind = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_col", 32'(bus.sp_col), 32'h1F);
    check_eq("rst_dout", 32'(bus.dout), 32'h0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'h0);
    rst_n = 1'b1;

    // CPU upload interleaves planes; readback returns the right plane
    cpu_rewind();
    cpu_write(8'h11); cpu_write(8'h22); cpu_write(8'h33); cpu_write(8'h44);
    cpu_rewind();
    cpu_read(rd); check_eq("cpu_rd0", 32'(rd), 32'h11);
    cpu_read(rd); check_eq("cpu_rd1", 32'(rd), 32'h22);

    // Full keymap for modifiers 0 and shift
    for (int a = 0; a < NADDR; a++)
      for (int k = 0; k < KPS; k++)
        km[k][a] = {3'($urandom_range(0, ROWS - 1)), 5'($urandom)};
    km[0][8'h1C]       = 8'b001_00001;  // A
    km[1][8'h1C]       = NULL_ENTRY;
    km[0][256 + 8'h1C] = 8'b001_00001;  // A
    km[1][256 + 8'h1C] = 8'b000_00001;  // CAPS
    cpu_rewind();
    for (int a = 0; a < NADDR; a++)
      for (int k = 0; k < KPS; k++) cpu_write(km[k][a]);
    cpu_rewind();
    cpu_read(rd); check_eq("up_rd0", 32'(rd), 32'(km[0][0]));
    cpu_read(rd); check_eq("up_rd1", 32'(rd), 32'(km[1][0]));
    cpu_read(rd); check_eq("up_rd2", 32'(rd), 32'(km[0][1]));
    cpu_read(rd); check_eq("up_rd3", 32'(rd), 32'(km[1][1]));

    // Press latency: visible three edges after the strobe edge
    @(negedge clk);
    bus.sp_row = 8'hFD; bus.modifiers = '0; bus.extended = 1'b0; bus.scan = 7'h1C;
    bus.released = 1'b0; bus.scan_received = 1'b1;
    @(negedge clk); bus.scan_received = 1'b0;
    @(negedge clk);
    @(negedge clk); check_eq("lat_e2", 32'(bus.sp_col), 32'h1F);
    @(negedge clk); check_eq("lat_e3", 32'(bus.sp_col), 32'h1E);
    model_event(3'b000, 1'b0, 7'h1C, 1'b0);
    repeat (2) @(negedge clk);
    check_matrix("a_press");
    send(3'b000, 1'b0, 7'h1C, 1'b1);
    check_matrix("a_rel");

    // Shifted press released without shift clears both planes' keys
    ms = '0; ms.shift = 1'b1;
    send(3'(ms), 1'b0, 7'h1C, 1'b0);
    check_matrix("shift_press");
    send(3'b000, 1'b0, 7'h1C, 1'b1);
    check_matrix("shift_rel");

    // Typematic repeats occupy one slot
    repeat (3) send(3'b000, 1'b0, 7'h1C, 1'b0);
    check_matrix("typ_press");
    send(3'b000, 1'b0, 7'h1C, 1'b1);
    check_matrix("typ_rel");

    // Slot table overflow
    for (int i = 0; i < 9; i++) send(3'b000, 1'b0, 7'(8'h10 + i), 1'b0);
    check_matrix("ovf_full");
    send(3'b000, 1'b0, 7'h10, 1'b1);
    send(3'b000, 1'b0, 7'h18, 1'b0);
    check_matrix("ovf_repress");
    kb_clean();
    check_matrix("kbclean");

    // Randomized event stream
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) kb_clean();
      else begin
        ms = '0; ms.shift = 1'($urandom_range(0, 1));
        ext = 1'($urandom_range(0, 1));
        sc  = 7'($urandom_range(8'h10, 8'h1F));
        rel = ($urandom_range(0, 2) == 0);
        send(3'(ms), ext, sc, rel);
      end
      rsel = ROWS'($urandom);
      bus.sp_row = rsel;
      #1;
      check_eq("rand_col", 32'(bus.sp_col), 32'(exp_col(rsel)));
      check_eq("rand_ovf", 32'(bus.overflow), 32'(ovf_m));
    end

    // Event strobed during a CPU read is serviced afterwards
    kb_clean();
    @(negedge clk); bus.cpuread = 1'b1;
    @(negedge clk);
    bus.modifiers = '0; bus.extended = 1'b0; bus.scan = 7'h1C; bus.released = 1'b0;
    bus.scan_received = 1'b1;
    @(negedge clk); bus.scan_received = 1'b0;
    @(negedge clk); bus.cpuread = 1'b0;
    repeat (8) @(negedge clk);
    model_event(3'b000, 1'b0, 7'h1C, 1'b0);
    check_matrix("cpu_pend");

    // Reset mid-write with keys held and overflow set
    kb_clean();
    for (int i = 0; i < 9; i++) send(3'b000, 1'b0, 7'(8'h10 + i), 1'b0);
    kb_clean();
    for (int i = 0; i < 3; i++) send(3'b000, 1'b1, 7'(8'h11 + i), 1'b0);
    check_matrix("pre_rst");
    @(negedge clk); bus.din = 8'h5A; bus.cpuwrite = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    bus.sp_row = '0;
    #1;
    check_eq("arst_col", 32'(bus.sp_col), 32'h1F);
    check_eq("arst_dout", 32'(bus.dout), 32'h0);
    check_eq("arst_ovf", 32'(bus.overflow), 32'h0);
    bus.cpuwrite = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    held.delete(); ovf_m = 1'b0;
    cpu_read(rd); check_eq("arst_rd0", 32'(rd), 32'(km[0][0]));
    cpu_read(rd); check_eq("arst_rd1", 32'(rd), 32'(km[1][0]));
    check_matrix("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
